hdd_sd_bridge: RTL

HDD_SD_BRIDGE -- requirements
Module: hdd_sd_bridge

---
 rtl/hdd_bridge_pkg.sv | 14 +
 rtl/hdd_ack_watchdog.sv | 48 ++++
 rtl/hdd_sd_bridge.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/hdd_bridge_pkg.sv
// Shared types for the Apple II HDD to HPS sector bridge.
// Holds the FSM state encoding and the default ack-watchdog limit.
package hdd_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2
    } state_e;

    // Roughly one second at the 14.318 MHz core clock.
    localparam logic [23:0] DEFAULT_TIMEOUT = 24'd14318180;

endpackage

// File: rtl/hdd_ack_watchdog.sv
// Ack watchdog for hdd_sd_bridge; only built when HDD_BRIDGE_TIMEOUT_EN is defined.
// Counts cycles spent in a busy state and flags expiry at LIMIT-1.
`ifdef HDD_BRIDGE_TIMEOUT_EN
module hdd_ack_watchdog
    import hdd_bridge_pkg::*;
#(
    parameter logic [23:0] LIMIT = DEFAULT_TIMEOUT
)
(
    input  logic   clk,
    input  logic   reset_n,
    input  state_e state,
    output logic   expired
);

    logic [23:0] count_r;
    logic [23:0] count_eff_s;
    state_e      prev_r;

    // A state differing from last cycle's means the FSM just moved, so the count restarts from zero.
    always_comb begin
        count_eff_s = count_r;
        if (state != prev_r) begin
            count_eff_s = 24'd0;
        end else begin
            count_eff_s = count_r;
        end
    end

    assign expired = (state != ST_IDLE) && (count_eff_s == (LIMIT - 24'd1));

    // Cycle counter, held at zero while idle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_r <= 24'd0;
            prev_r  <= ST_IDLE;
        end else begin
            prev_r <= state;
            if (state == ST_IDLE) begin
                count_r <= 24'd0;
            end else begin
                count_r <= count_eff_s + 24'd1;
            end
        end
    end

endmodule
`endif

// File: rtl/hdd_sd_bridge.sv
// Bridges Apple II HDD sector requests to the HPS sd_rd/sd_wr/sd_ack handshake.
// Optional ack watchdog enabled by defining HDD_BRIDGE_TIMEOUT_EN.
module hdd_sd_bridge
    import hdd_bridge_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CYCLES = DEFAULT_TIMEOUT
)
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        hdd_read,
    input  logic        hdd_write,
    input  logic        img_mounted,
    input  logic [63:0] img_size,
    input  logic        img_readonly,
    input  logic        sd_ack,
    output logic        sd_rd,
    output logic        sd_wr,
    output logic        cpu_wait,
    output logic        hdd_mounted,
    output logic        hdd_protect,
    output logic        hdd_error
);

    state_e state_r;
    logic   rd_pend_r;
    logic   wr_pend_r;
    logic   ack_prev_r;
    logic   serve_wr_r;
    logic   sd_rd_r;
    logic   sd_wr_r;
    logic   cpu_wait_r;
    logic   error_r;
    // Mount status has no reset so it survives warm and cold resets.
    logic   mounted_r = 1'b0;
    logic   protect_r = 1'b0;

    logic   rd_req_s;
    logic   wr_req_s;
    logic   ack_rise_s;
    logic   ack_fall_s;
    logic   unmount_s;
    logic   timeout_s;

    assign rd_req_s   = rd_pend_r | hdd_read;
    assign wr_req_s   = wr_pend_r | hdd_write;
    assign ack_rise_s = sd_ack & ~ack_prev_r;
    assign ack_fall_s = ~sd_ack & ack_prev_r;
    assign unmount_s  = img_mounted & (img_size == 64'd0);

`ifdef HDD_BRIDGE_TIMEOUT_EN
    hdd_ack_watchdog #(
        .LIMIT   (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .state   (state_r),
        .expired (timeout_s)
    );
`else
    // No watchdog: wait for sd_ack indefinitely.
    assign timeout_s = 1'b0 & (TIMEOUT_CYCLES == 24'd0);
`endif

    // Image mount status, sampled only on the mount pulse.
    always_ff @(posedge clk) begin
        if (img_mounted) begin
            mounted_r <= (img_size != 64'd0);
            protect_r <= img_readonly;
        end
    end

    // Request FSM with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            rd_pend_r  <= 1'b0;
            wr_pend_r  <= 1'b0;
            ack_prev_r <= 1'b0;
            serve_wr_r <= 1'b0;
            sd_rd_r    <= 1'b0;
            sd_wr_r    <= 1'b0;
            cpu_wait_r <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            ack_prev_r <= sd_ack;
            rd_pend_r  <= rd_req_s;
            wr_pend_r  <= wr_req_s;
            case (state_r)
                ST_IDLE: begin
                    sd_rd_r    <= 1'b0;
                    sd_wr_r    <= 1'b0;
                    cpu_wait_r <= 1'b0;
                    if (!mounted_r) begin
                        if (rd_req_s | wr_req_s) begin
                            rd_pend_r <= 1'b0;
                            wr_pend_r <= 1'b0;
                            error_r   <= 1'b1;
                        end
                    end else if (rd_req_s) begin
                        state_r    <= ST_REQ;
                        sd_rd_r    <= 1'b1;
                        cpu_wait_r <= 1'b1;
                        serve_wr_r <= 1'b0;
                        error_r    <= 1'b0;
                    end else if (wr_req_s) begin
                        if (protect_r) begin
                            wr_pend_r <= 1'b0;
                            error_r   <= 1'b1;
                        end else begin
                            state_r    <= ST_REQ;
                            sd_wr_r    <= 1'b1;
                            cpu_wait_r <= 1'b1;
                            serve_wr_r <= 1'b1;
                            error_r    <= 1'b0;
                        end
                    end
                end
                ST_REQ: begin
                    if (ack_rise_s) begin
                        state_r <= ST_XFER;
                        sd_rd_r <= 1'b0;
                        sd_wr_r <= 1'b0;
                        // A fresh pulse in this very cycle stays latched.
                        if (serve_wr_r) begin
                            wr_pend_r <= hdd_write;
                        end else begin
                            rd_pend_r <= hdd_read;
                        end
                    end
                end
                ST_XFER: begin
                    if (ack_fall_s) begin
                        state_r    <= ST_IDLE;
                        cpu_wait_r <= serve_wr_r ? rd_req_s : wr_req_s;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    sd_rd_r    <= 1'b0;
                    sd_wr_r    <= 1'b0;
                    cpu_wait_r <= 1'b0;
                end
            endcase
            if (timeout_s) begin
                state_r    <= ST_IDLE;
                sd_rd_r    <= 1'b0;
                sd_wr_r    <= 1'b0;
                cpu_wait_r <= 1'b0;
                error_r    <= 1'b1;
                if (serve_wr_r) begin
                    wr_pend_r <= hdd_write;
                end else begin
                    rd_pend_r <= hdd_read;
                end
            end
            // Image removed under an active transfer: abandon everything.
            if (unmount_s && (state_r != ST_IDLE)) begin
                state_r    <= ST_IDLE;
                sd_rd_r    <= 1'b0;
                sd_wr_r    <= 1'b0;
                cpu_wait_r <= 1'b0;
                rd_pend_r  <= 1'b0;
                wr_pend_r  <= 1'b0;
                error_r    <= 1'b1;
            end
        end
    end

    assign sd_rd       = sd_rd_r;
    assign sd_wr       = sd_wr_r;
    assign cpu_wait    = cpu_wait_r;
    assign hdd_mounted = mounted_r;
    assign hdd_protect = protect_r;
    assign hdd_error   = error_r;

endmodule
